// File: rtl/pipe_arith_vr.sv
// pipe_arith_vr: stallable 3-stage pipeline computing F = ((A+B) +/- (C-D)) * D
// at full precision in signed two's complement.
// Uses valid/ready handshakes upstream and downstream. Empty stages fill
// even while the output is stalled.
module pipe_arith_vr #(
    parameter int N     = 10,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    input  logic [N-1:0]       in_c,
    input  logic [N-1:0]       in_d,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N+1:0]     out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    // Stage valid bits; stage 3 is the output register.
    logic               v1_reg, v2_reg, v3_reg;
    // Stage 1 registers.
    logic [N:0]         x1_reg, x2_reg;
    logic [N-1:0]       d1_reg;
    logic               mode1_reg;
    logic [TAG_W-1:0]   tag1_reg;
    // Stage 2 registers.
    logic [N+1:0]       x3_reg;
    logic [N-1:0]       d2_reg;
    logic [TAG_W-1:0]   tag2_reg;
    // Stage 3 registers.
    logic [2*N+1:0]     out_data_reg;
    logic [TAG_W-1:0]   tag3_reg;

    logic               adv1, adv2, adv3;

    // Sign-extended operands and stage results. Plain bit-vector arithmetic
    // on explicitly sign-extended values gives the two's-complement result.
    logic [N:0]         a_ext, b_ext, c_ext, d_ext;
    logic [N:0]         x1_next, x2_next;
    logic [N+1:0]       x1_ext, x2_ext, x3_next;
    logic [2*N+1:0]     x3_wide, d_wide, prod_next;

    assign a_ext   = {in_a[N-1], in_a};
    assign b_ext   = {in_b[N-1], in_b};
    assign c_ext   = {in_c[N-1], in_c};
    assign d_ext   = {in_d[N-1], in_d};
    assign x1_next = a_ext + b_ext;
    assign x2_next = c_ext - d_ext;

    assign x1_ext  = {x1_reg[N], x1_reg};
    assign x2_ext  = {x2_reg[N], x2_reg};
    assign x3_next = mode1_reg ? (x1_ext - x2_ext) : (x1_ext + x2_ext);

    // The low 2N+2 bits of the product of the sign-extended operands are
    // exact, because |x3 * D| always fits in 2N+2 signed bits.
    assign x3_wide   = {{N{x3_reg[N+1]}}, x3_reg};
    assign d_wide    = {{(N+2){d2_reg[N-1]}}, d2_reg};
    assign prod_next = x3_wide * d_wide;

    // A stage may load when it is empty or when its successor is moving.
    assign adv3 = !v3_reg | out_ready;
    assign adv2 = !v2_reg | adv3;
    assign adv1 = !v1_reg | adv2;

    assign in_ready  = adv1;
    assign out_valid = v3_reg;
    assign out_data  = out_data_reg;
    assign out_tag   = tag3_reg;
    assign busy      = v1_reg | v2_reg | v3_reg;

    // Stage 1: capture the two partial sums, D, the mode and the tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            x1_reg    <= '0;
            x2_reg    <= '0;
            d1_reg    <= '0;
            mode1_reg <= 1'b0;
            tag1_reg  <= '0;
        end else if (adv1) begin
            v1_reg    <= in_valid;
            x1_reg    <= x1_next;
            x2_reg    <= x2_next;
            d1_reg    <= in_d;
            mode1_reg <= in_mode;
            tag1_reg  <= in_tag;
        end
    end

    // Stage 2: combine the partial sums; D travels with its own transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg   <= 1'b0;
            x3_reg   <= '0;
            d2_reg   <= '0;
            tag2_reg <= '0;
        end else if (adv2) begin
            v2_reg   <= v1_reg;
            x3_reg   <= x3_next;
            d2_reg   <= d1_reg;
            tag2_reg <= tag1_reg;
        end
    end

    // Stage 3: the output register holds the product until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_reg       <= 1'b0;
            out_data_reg <= '0;
            tag3_reg     <= '0;
        end else if (adv3) begin
            v3_reg       <= v2_reg;
            out_data_reg <= prod_next;
            tag3_reg     <= tag2_reg;
        end
    end

endmodule

// File: tb/tb_pipe_arith_vr.sv
// Directed testbench for pipe_arith_vr (N=10, TAG_W=4) with hand-computed
// expected results.
module tb_pipe_arith_vr;
    localparam int N     = 10;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N-1:0]       in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic               in_mode = 1'b0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*N+1:0]     out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    // Expected data for transactions built by drive_k(k), k = 1..4:
    // A=B=C=k, D=-2, mode=1 -> x1=2k, x2=k+2, x3=k-2, F=4-2k.
    longint exp_k [1:4] = '{2, 0, -2, -4};

    pipe_arith_vr #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic longint data_s();
        return longint'($signed(out_data));
    endfunction

    task automatic drive(input int a, input int b, input int c, input int d,
                         input logic m, input int t);
        in_a     = a[N-1:0];
        in_b     = b[N-1:0];
        in_c     = c[N-1:0];
        in_d     = d[N-1:0];
        in_mode  = m;
        in_tag   = t[TAG_W-1:0];
        in_valid = 1'b1;
    endtask

    task automatic drive_k(input int k);
        drive(k, k, k, -2, 1'b1, k);
    endtask

    // One isolated transaction with out_ready=1; checks latency, data and tag.
    task automatic run_one(input string name, input int a, input int b, input int c,
                           input int d, input logic m, input int t, input longint exp);
        @(negedge clk);
        drive(a, b, c, d, m, t);
        check_val({name, "_in_ready"}, longint'(in_ready), 1);
        @(posedge clk);              // accept edge t
        @(negedge clk);
        in_valid = 1'b0;
        check_val({name, "_lat1_valid"}, longint'(out_valid), 0);
        @(posedge clk);              // edge t+1
        @(negedge clk);
        check_val({name, "_lat2_valid"}, longint'(out_valid), 0);
        @(posedge clk);              // edge t+2
        @(negedge clk);
        check_val({name, "_valid"}, longint'(out_valid), 1);
        check_val({name, "_data"}, data_s(), exp);
        check_val({name, "_tag"}, longint'(out_tag), longint'(t));
        $display("txn %s tag=%0d data=%0d", name, out_tag, data_s());
    endtask

    // Drain the pipe with out_ready=1, expecting tags first..last on consecutive cycles.
    task automatic drain_k(input string name, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            check_val({name, "_valid"}, longint'(out_valid), 1);
            check_val({name, "_tag"}, longint'(out_tag), longint'(k));
            check_val({name, "_data"}, data_s(), exp_k[k]);
            $display("txn %s tag=%0d data=%0d", name, out_tag, data_s());
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        check_val({name, "_empty_valid"}, longint'(out_valid), 0);
        check_val({name, "_empty_busy"}, longint'(busy), 0);
    endtask

    initial begin
        int stale;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_in_ready", longint'(in_ready), 1);
        check_val("rst_out_data", data_s(), 0);
        check_val("rst_out_tag", longint'(out_tag), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic, mode and extreme vectors
        run_one("basic", 5, 3, 10, 2, 1'b0, 3, 32);
        run_one("mode1", 5, 3, 10, 2, 1'b1, 5, 0);
        run_one("mode1b", 7, 0, 1, -3, 1'b1, 6, -9);
        run_one("ext_neg", -512, -512, -512, 511, 1'b0, 7, -1046017);
        run_one("ext_pos", 511, 511, 511, -512, 1'b0, 8, -1047040);

        // Backpressure: four back-to-back inputs, only three accepted
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_k(k);
            @(posedge clk);
            @(negedge clk);
        end
        drive_k(4);
        check_val("bp_full_in_ready", longint'(in_ready), 0);
        check_val("bp_full_busy", longint'(busy), 1);
        check_val("bp_full_out_tag", longint'(out_tag), 1);
        @(posedge clk);
        @(negedge clk);
        check_val("bp_stall_in_ready", longint'(in_ready), 0);
        check_val("bp_stall_data", data_s(), exp_k[1]);
        check_val("bp_stall_tag", longint'(out_tag), 1);
        out_ready = 1'b1;
        #1;
        check_val("bp_release_in_ready", longint'(in_ready), 1);
        drain_k("bp", 1, 4);

        // Bubble collapse: tag 1, idle cycle, tag 2, then tag 3 fills the pipe
        out_ready = 1'b0;
        drive_k(1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_k(2);
        check_val("bub_in_ready2", longint'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        drive_k(3);
        check_val("bub_in_ready3", longint'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("bub_full_in_ready", longint'(in_ready), 0);
        check_val("bub_full_tag", longint'(out_tag), 1);
        out_ready = 1'b1;
        drain_k("bub", 1, 3);

        // Reset with three transactions in flight
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_k(k);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("mid_pre_busy", longint'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", longint'(out_valid), 0);
        check_val("mid_rst_busy", longint'(busy), 0);
        check_val("mid_rst_out_data", data_s(), 0);
        check_val("mid_rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("mid_post_in_ready", longint'(in_ready), 1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_val("mid_no_stale", longint'(stale), 0);
        run_one("post_rst", 5, 3, 10, 2, 1'b0, 9, 32);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_arith_vr.md
Name: pipe_arith_vr

Overview:
- Parametrised, stallable 3-stage pipelined arithmetic unit.
- Computes F = ((A+B) ± (C−D)) × D per transaction at full precision, in signed two's complement.
- Each transaction carries a mode bit and a user tag. Upstream and downstream use valid/ready handshakes.
- Sits in the datapath as the general replacement for fixed, free-running arithmetic pipelines: it adds reset, backpressure, bubble collapse and per-transaction mode.

Parameters:
- N, 10, operand width in bits (signed), N ≥ 2.
- TAG_W, 4, width of the opaque tag carried alongside each transaction, TAG_W ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents a transaction.
- in_ready  out  1  block can accept; transfer occurs when in_valid & in_ready are high at a rising edge.
- in_a, in_b, in_c, in_d  in  N each  signed operands A, B, C, D.
- in_mode  in  1  0: x3 = x1 + x2; 1: x3 = x1 − x2.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result register holds a valid transaction.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid & out_ready are high at a rising edge.
- out_data  out  2N+2  signed result F.
- out_tag  out  TAG_W  tag of the transaction on out_data.
- busy  out  1  OR of the three stage valid bits.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid and busy go to 0 immediately. out_data, out_tag and all internal data/tag registers clear to 0. in_ready is 1 after reset.
- Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Stage 1, at accept:
  - x1 = A+B, N+1 bits, sign-extended operands.
  - x2 = C−D, N+1 bits.
  - D, mode and tag are registered alongside x1 and x2.
- Stage 2: x3 = x1 ± x2 per the registered mode, N+2 bits. D and tag advance with it. The D used in the product is always the D of the same transaction; it is never re-sampled from the input.
- Stage 3 (output register): out_data = x3 × D, signed, 2N+2 bits. Full precision: no overflow, wrap or saturation is possible.
- Advance rules, with vK = stage K valid and v3 = out_valid:
  - adv3 = !v3 | out_ready
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - in_ready = adv1 (combinational path from out_ready is permitted).
- Stage K loads from stage K−1 when advK holds. Its valid becomes the upstream valid, i.e. in_valid for stage 1.
- A stage whose advK is false holds its data, tag and valid unchanged.
- Bubbles collapse: an empty stage loads even while downstream is stalled.
- Latency: a transaction accepted at edge t reaches stage 2 at edge t+1 and the output register at edge t+2. out_valid is high in the cycle following edge t+2.
- Throughput: one transaction per cycle while out_ready stays high.
- Ordering: strictly in order; no transaction is dropped or duplicated.
- out_data and out_tag are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit in the same cycle with a full pipeline is legal and sustains throughput.
- Full pipe with out_ready=0: all three valids are 1 and in_ready=0. Releasing out_ready raises in_ready combinationally in that same cycle.
- Empty pipe: busy=0, out_valid=0.
- in_* inputs are don't-care when in_valid=0 or in_ready=0.

Test Plan (N=10, TAG_W=4):
- Basic: A=5, B=3, C=10, D=2, mode=0, tag=0x3, out_ready=1 → out_valid in the cycle after accept edge +2; out_data=32, out_tag=0x3.
- Mode 1: same operands with mode=1 → out_data=0. Then A=7, B=0, C=1, D=−3, mode=1 → x1=7, x2=4, x3=3, out_data=−9.
- Extremes:
  - A=B=C=−512, D=511 → out_data=−1046017.
  - A=B=C=511, D=−512 → out_data=−1047040.
  - No wrap in either case.
- Backpressure: out_ready=0, four back-to-back inputs tagged 1..4 → three accepted, in_ready=0 with the fourth held. Raise out_ready → tags 1,2,3,4 emerge on consecutive cycles with correct data; out_data stays stable while stalled.
- Bubble collapse: accept tag 1, idle one cycle, accept tag 2, with out_ready=0 → both occupy adjacent stages with no gap; in_ready stays 1 until three stages are full.
- Reset mid-operation: rst_n low with three transactions in flight → out_valid, busy and out_data go to 0 without waiting for a clock edge. After release, in_ready=1 and no stale transaction is ever emitted.
